mesh_reader: RTL and testbench
==============================

MESH_READER -- requirements
Module: mesh_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 The ports SHALL be:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sequencer start request
- word_count  in  32  number of result words to stream
- RAM_RES_Do  in  32  result RAM read data
- RAM_RES_EN  out  1  result RAM enable
- RAM_RES_A  out  9  result RAM word address
- RAM_RES_WE  out  4  result RAM byte write enables
- RAM_RES_Di  out  32  result RAM write data
- out_data  out  32  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word
- out_last  out  1  final word of the stream
- busy  out  1  operation in progress
- checksum  out  32  running sum of emitted words

Function
REQ-003 The FSM SHALL have states IDLE, READ and DRAIN; busy SHALL be 1 in every state except IDLE.
REQ-004 In IDLE, start=1 at a rising edge SHALL latch word_count and enter READ; start SHALL be ignored in READ and DRAIN, so a multi-cycle start pulse gives exactly one run.
REQ-005 The effective count SHALL be min(word_count, 512); addresses SHALL run 0 to count-1 with no wrap.
REQ-006 word_count=0 SHALL hold busy for exactly one cycle, emit no words and return to IDLE.
REQ-007 RAM read latency SHALL be 1 cycle: EN=1 with address A in cycle N gives valid RAM_RES_Do at the rising edge ending cycle N+1, which SHALL be written into the FIFO.
REQ-008 RAM_RES_WE SHALL be 0 and RAM_RES_Di SHALL be 0 at all times; EN SHALL be 0 outside READ.
REQ-009 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 2, so the FIFO never overflows.
REQ-010 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; a word is consumed when out_valid and out_ready are both 1 at a rising edge.
REQ-011 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 out_last SHALL be 1 only while the head word is word count-1.
REQ-013 With out_ready held 1, the first out_valid SHALL appear 2 cycles after start is sampled, with one word per cycle sustained after that.
REQ-014 READ SHALL change to DRAIN after the last address is issued; DRAIN SHALL change to IDLE on the edge where the out_last handshake occurs, and busy SHALL drop the cycle after that handshake.
REQ-015 A FIFO push and pop in the same edge SHALL leave occupancy unchanged, with data order preserved.

Reset
REQ-016 rst=1 SHALL immediately force IDLE and set busy, out_valid, out_last, RAM_RES_EN, RAM_RES_A, out_data and checksum to 0, and SHALL empty the FIFO, including mid-operation.
REQ-017 After rst is released, the block SHALL need a fresh start to run; a start held through reset SHALL be sampled at the first edge after release.

Configuration
REQ-018 When the macro MESH_READER_CHECKSUM_EN is defined, checksum SHALL clear on start and add each consumed word mod 2^32, and SHALL be final when busy falls.
REQ-019 When MESH_READER_CHECKSUM_EN is undefined, checksum SHALL be constant 0 and the adder SHALL not exist.

Structure
REQ-020 The shared package subsurf_pkg SHALL hold RAM_ADDR_W=9, RAM_DATA_W=32, MAX_WORDS=512 and the mesh_reader state enum.
REQ-021 The 2-entry FIFO SHALL be a separate sub-module, mesh_reader_fifo, with push/pop/full/empty and an occupancy count.

Verification
REQ-022 RAM holds A[i]=i+100, word_count=4, out_ready=1 -> out_data 100,101,102,103 on consecutive cycles, out_last on 103, busy falls the next cycle.
REQ-023 word_count=0 -> busy high for exactly 1 cycle, out_valid never 1, RAM_RES_EN never 1.
REQ-024 word_count=8, out_ready toggling 1,0,0,1 -> all 8 words in order, none dropped or duplicated, out_data stable while stalled, RAM_RES_EN never issues a read that would overflow the FIFO.
REQ-025 word_count=1000 -> exactly 512 words, last address 511, out_last on the word from address 511.
REQ-026 rst asserted after the 3rd word of 10 -> outputs 0 the same cycle; a new start with word_count=2 -> words A[0], A[1] only.
REQ-027 With MESH_READER_CHECKSUM_EN, A[i]=0xFFFFFFFF for 2 words -> checksum 0xFFFFFFFE; without the macro -> checksum 0.

Source files
------------

// File: rtl/subsurf_pkg.sv
// Shared constants, the mesh_reader state encoding and a word-count clamp helper.
package subsurf_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 32;
  localparam int MAX_WORDS  = 512;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } mr_state_e;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [31:0] wc);
    if (wc > 32'(MAX_WORDS)) return CNT_W'(MAX_WORDS);
    else                     return wc[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mesh_reader_fifo.sv
// Two-entry FIFO; a push and pop on the same edge keep occupancy and ordering intact.
module mesh_reader_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mesh_reader.sv
// Streams min(word_count,512) words from the result RAM through a 2-entry FIFO.
// Optional running checksum enabled by defining MESH_READER_CHECKSUM_EN.
module mesh_reader
  import subsurf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           word_count,
  input  logic [RAM_DATA_W-1:0] RAM_RES_Do,
  output logic                  RAM_RES_EN,
  output logic [RAM_ADDR_W-1:0] RAM_RES_A,
  output logic [3:0]            RAM_RES_WE,
  output logic [RAM_DATA_W-1:0] RAM_RES_Di,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           checksum
);

  mr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]  pop_idx_q, pop_idx_d;
  logic              inflight_q;
  logic              rd_en, pop, room;
  logic [RAM_DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_cnt;
  logic [2:0]        level;

  mesh_reader_fifo #(.DATA_W(RAM_DATA_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (RAM_RES_Do),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_head;
  assign pop        = out_valid && out_ready;
  assign out_last   = out_valid && (pop_idx_q == count_q - CNT_W'(1));
  assign busy       = (state_q != ST_IDLE);
  assign RAM_RES_EN = rd_en;
  assign RAM_RES_A  = issue_idx_q[RAM_ADDR_W-1:0];
  assign RAM_RES_WE = '0;
  assign RAM_RES_Di = '0;

  // Credit the word leaving this edge so a full-rate stream never bubbles.
  assign level = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign room  = level < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issue_idx_d = issue_idx_q;
    pop_idx_d   = pop ? pop_idx_q + CNT_W'(1) : pop_idx_q;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d     = clamp_count(word_count);
          issue_idx_d = '0;
          pop_idx_d   = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else if (room) begin
          rd_en       = 1'b1;
          issue_idx_d = issue_idx_q + CNT_W'(1);
          if (issue_idx_q == count_q - CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      issue_idx_q <= '0;
      pop_idx_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issue_idx_q <= issue_idx_d;
      pop_idx_q   <= pop_idx_d;
      inflight_q  <= rd_en;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight_q && fifo_full && !pop));

`ifdef MESH_READER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && start) chk_d = '0;
    else if (pop)                    chk_d = chk_q + out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mesh_reader.sv
// Directed bench for mesh_reader: vector table of runs plus reset and checksum sequences.
module tb_mesh_reader;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [31:0] word_count, RAM_RES_Do, RAM_RES_Di, out_data, checksum;
  logic        RAM_RES_EN, out_valid, out_last, busy;
  logic [8:0]  RAM_RES_A;
  logic [3:0]  RAM_RES_WE;

  logic [31:0] ram [512];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (RAM_RES_EN) RAM_RES_Do <= ram[RAM_RES_A];

  mesh_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .RAM_RES_Do (RAM_RES_Do),
    .RAM_RES_EN (RAM_RES_EN),
    .RAM_RES_A  (RAM_RES_A),
    .RAM_RES_WE (RAM_RES_WE),
    .RAM_RES_Di (RAM_RES_Di),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] wc;
    logic [3:0]  pat;       // out_ready for cycle k is pat[k%4]
    int          hold;      // cycles start is held high
    int          exp_n;
    int          exp_busy;  // 0: not checked (stalling patterns)
  } vec_t;

  // Caller invokes this just after a negedge; start is sampled at the next posedge.
  task automatic run_case(input logic [31:0] wc, input logic [3:0] pat, input int hold,
                          input int exp_n, input int exp_busy);
    int rx, issued, lasts, first_v, last_k, last_addr, busy_cycles;
    logic [31:0] exp_sum, prev_data;
    logic prev_stall, hs, done;
    rx = 0; issued = 0; lasts = 0; first_v = -1; last_k = -1; last_addr = -1;
    busy_cycles = 0; exp_sum = '0; prev_data = '0; prev_stall = 1'b0; done = 1'b0;
    start = 1'b1;
    word_count = wc;
    @(posedge clk);
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      start = (k < hold - 1);
      out_ready = pat[k % 4];
      #1;
      if (k == 0) check("busy_start", {31'b0, busy}, 32'd1);
      if (!busy) begin
        done = 1'b1;
        busy_cycles = k;
        check("en_idle", {31'b0, RAM_RES_EN}, 32'd0);
      end else begin
        hs = out_valid && out_ready;
        check("ram_we", {28'b0, RAM_RES_WE}, 32'd0);
        check("ram_di", RAM_RES_Di, 32'd0);
        if (prev_stall) begin
          check("stall_valid", {31'b0, out_valid}, 32'd1);
          check("stall_data", out_data, prev_data);
        end
        if (RAM_RES_EN) begin
          check("rd_addr", {23'b0, RAM_RES_A}, 32'(issued));
          check("rd_room", {31'b0, (issued - rx - int'(hs)) < 2}, 32'd1);
          check("rd_range", {31'b0, issued < exp_n}, 32'd1);
          last_addr = int'(RAM_RES_A);
          issued++;
        end
        if (out_valid) begin
          if (first_v < 0) first_v = k;
          check("data", out_data, ram[rx % 512]);
          check("last", {31'b0, out_last}, {31'b0, rx == exp_n - 1});
        end else begin
          check("last_novalid", {31'b0, out_last}, 32'd0);
        end
        if (hs) begin
`ifdef MESH_READER_CHECKSUM_EN
          exp_sum = exp_sum + ram[rx % 512];
`endif
          if (out_last) begin
            last_k = k;
            lasts++;
          end
          rx++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!done) check("timeout", 32'd0, 32'd1);
    check("n_words", 32'(rx), 32'(exp_n));
    check("n_reads", 32'(issued), 32'(exp_n));
    check("n_last", 32'(lasts), (exp_n > 0) ? 32'd1 : 32'd0);
    if (exp_n > 0) begin
      check("last_addr", 32'(last_addr), 32'(exp_n - 1));
      check("busy_drop", 32'(busy_cycles), 32'(last_k + 1));
    end
    if (exp_busy > 0) begin
      check("busy_len", 32'(busy_cycles), 32'(exp_busy));
      if (exp_n > 0) check("first_valid", 32'(first_v), 32'd2);
    end
    check("checksum", checksum, exp_sum);
  endtask

  vec_t vecs [6];
  int   hs_cnt;

  initial begin
    vecs[0] = '{32'd4,    4'b1111, 3, 4,   6};
    vecs[1] = '{32'd0,    4'b1111, 1, 0,   1};
    vecs[2] = '{32'd8,    4'b1001, 1, 8,   0};
    vecs[3] = '{32'd1000, 4'b1111, 1, 512, 514};
    vecs[4] = '{32'd1,    4'b1111, 1, 1,   3};
    vecs[5] = '{32'd3,    4'b0101, 2, 3,   0};

    for (int i = 0; i < 512; i++) ram[i] = 32'(i + 100);
    rst = 1'b1; start = 1'b0; word_count = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, busy},       32'd0);
    check("rst_valid", {31'b0, out_valid},  32'd0);
    check("rst_last",  {31'b0, out_last},   32'd0);
    check("rst_en",    {31'b0, RAM_RES_EN}, 32'd0);
    check("rst_addr",  {23'b0, RAM_RES_A},  32'd0);
    check("rst_data",  out_data,            32'd0);
    check("rst_csum",  checksum,            32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_case(vecs[v].wc, vecs[v].pat, vecs[v].hold, vecs[v].exp_n, vecs[v].exp_busy);

    // Reset in the middle of a 10-word run, start held through reset.
    @(negedge clk);
    start = 1'b1; word_count = 32'd10; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs_cnt++;
      if (hs_cnt == 3) break;
    end
    check("mid_hs", 32'(hs_cnt), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_busy",  {31'b0, busy},       32'd0);
    check("mid_valid", {31'b0, out_valid},  32'd0);
    check("mid_last",  {31'b0, out_last},   32'd0);
    check("mid_en",    {31'b0, RAM_RES_EN}, 32'd0);
    check("mid_addr",  {23'b0, RAM_RES_A},  32'd0);
    check("mid_data",  out_data,            32'd0);
    check("mid_csum",  checksum,            32'd0);
    start = 1'b1; word_count = 32'd2;
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    run_case(32'd2, 4'b1111, 1, 2, 4);

    // Wrap-around of the checksum adder.
    @(negedge clk);
    ram[0] = 32'hFFFF_FFFF;
    ram[1] = 32'hFFFF_FFFF;
    run_case(32'd2, 4'b1111, 1, 2, 4);
`ifdef MESH_READER_CHECKSUM_EN
    check("csum_wrap", checksum, 32'hFFFF_FFFE);
`else
    check("csum_off", checksum, 32'd0);
`endif
    ram[0] = 32'd100;
    ram[1] = 32'd101;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
